// File: rtl/sevseg_pkg.sv
// Shared types and segment encoding for the seven-segment scan driver.
package sevseg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StConvert,
    StCommit
  } state_e;

  // Active-low segments, bit0 = a ... bit6 = g; all off.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Hex digit to active-low segment pattern.
  function automatic logic [6:0] hex2seg(input logic [3:0] d);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (d)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sevseg_bin2bcd.sv
// Sequential double-dabble: 8-bit binary to three BCD digits in 8 cycles.
module sevseg_bin2bcd (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [7:0] bin_i,
  output logic       done_o,
  output logic [3:0] bcd2_o,
  output logic [3:0] bcd1_o,
  output logic [3:0] bcd0_o
);

  // Hundreds never exceeds 2 for an 8-bit input, so two bits suffice.
  logic [1:0] hun_q, hun_d;
  logic [3:0] ten_q, ten_d, one_q, one_d;
  logic [3:0] ten_adj, one_adj;
  logic [7:0] sh_q, sh_d;
  logic [3:0] cnt_q, cnt_d;

  // Add-3 correction then shift one binary bit into the BCD columns.
  always_comb begin
    ten_adj = (ten_q >= 4'd5) ? ten_q + 4'd3 : ten_q;
    one_adj = (one_q >= 4'd5) ? one_q + 4'd3 : one_q;
    hun_d   = hun_q;
    ten_d   = ten_q;
    one_d   = one_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    if (start_i) begin
      hun_d = 2'd0;
      ten_d = 4'd0;
      one_d = 4'd0;
      sh_d  = bin_i;
      cnt_d = 4'd8;
    end else if (cnt_q != 4'd0) begin
      {hun_d, ten_d, one_d, sh_d} = {hun_q[0], ten_adj, one_adj, sh_q, 1'b0};
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Conversion state registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hun_q <= 2'd0;
      ten_q <= 4'd0;
      one_q <= 4'd0;
      sh_q  <= 8'd0;
      cnt_q <= 4'd0;
    end else begin
      hun_q <= hun_d;
      ten_q <= ten_d;
      one_q <= one_d;
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  // High in the cycle whose closing edge performs the final step.
  assign done_o = (cnt_q == 4'd1);
  assign bcd2_o = {2'b00, hun_q};
  assign bcd1_o = ten_q;
  assign bcd0_o = one_q;

endmodule

// File: rtl/sevseg_scan_driver.sv
// Byte to 3-digit multiplexed common-anode display with change flash.
module sevseg_scan_driver #(
  parameter int unsigned SCAN_DIV      = 50000,
  parameter int unsigned FLASH_DIV     = 12500000,
  parameter int unsigned FLASH_TOGGLES = 6
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] value_i,
  input  logic       hex_mode_i,
  input  logic       enable_i,
  output logic [6:0] seg_n_o,
  output logic [2:0] dig_n_o,
  output logic       busy_o
);
  import sevseg_pkg::*;

  localparam int unsigned PrescW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned HalfW  = $clog2(FLASH_DIV + 1);
  localparam int unsigned TogW   = $clog2(FLASH_TOGGLES + 1);

  state_e            state_q, state_d;
  logic [7:0]        src_q, src_d, last_value_q, last_value_d;
  logic              last_mode_q, last_mode_d, pending_q, pending_d;
  logic [11:0]       digits_q, digits_d, new_digits;
  logic [2:0]        blank_q, blank_d, new_blank;
  logic [PrescW-1:0] presc_q, presc_d;
  logic [1:0]        idx_q, idx_d;
  logic [TogW-1:0]   tog_q, tog_d;
  logic [HalfW-1:0]  half_q, half_d;
  logic [6:0]        seg_n_q, seg_n_d;
  logic [2:0]        dig_n_q, dig_n_d;
  logic              changed, load, commit, conv_start, conv_done;
  logic              tick, flash_restart, flash_dark, cur_blank;
  logic [3:0]        bcd2, bcd1, bcd0, cur;

  assign changed    = {value_i, hex_mode_i} != {last_value_q, last_mode_q};
  assign conv_start = load & ~hex_mode_i;

  sevseg_bin2bcd u_bin2bcd (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .start_i (conv_start),
    .bin_i   (value_i),
    .done_o  (conv_done),
    .bcd2_o  (bcd2),
    .bcd1_o  (bcd1),
    .bcd0_o  (bcd0)
  );

  // Digit set produced by the conversion in flight, with leading-zero blanking.
  always_comb begin
    if (last_mode_q) begin
      new_digits = {4'd0, src_q};
      new_blank  = 3'b100;
    end else begin
      new_digits = {bcd2, bcd1, bcd0};
      new_blank  = {bcd2 == 4'd0, (bcd2 == 4'd0) && (bcd1 == 4'd0), 1'b0};
    end
  end

  // Conversion FSM; COMMIT re-checks the input so back-to-back changes never idle.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    last_value_d = last_value_q;
    last_mode_d  = last_mode_q;
    pending_d    = pending_q;
    digits_d     = digits_q;
    blank_d      = blank_q;
    load         = 1'b0;
    commit       = 1'b0;
    unique case (state_q)
      StIdle:    load = changed;
      StConvert: if (conv_done) state_d = StCommit;
      StCommit: begin
        commit = 1'b1;
        if (changed || pending_q) load = 1'b1;
        else state_d = StIdle;
      end
      default:   state_d = StIdle;
    endcase
    if ((state_q != StIdle) && changed) pending_d = 1'b1;
    if (load) begin
      src_d        = value_i;
      last_value_d = value_i;
      last_mode_d  = hex_mode_i;
      pending_d    = 1'b0;
      state_d      = hex_mode_i ? StCommit : StConvert;
    end
    if (commit) begin
      digits_d = new_digits;
      blank_d  = new_blank;
    end
  end

  // Flash sequencer; tog counts down half-periods, dark while it is even and non-zero.
  assign flash_restart = commit && ({new_blank, new_digits} != {blank_q, digits_q});
  assign flash_dark    = (tog_q != '0) && !tog_q[0];

  always_comb begin
    tog_d  = tog_q;
    half_d = half_q;
    if (flash_restart) begin
      tog_d  = TogW'(FLASH_TOGGLES);
      half_d = HalfW'(FLASH_DIV);
    end else if (tog_q != '0) begin
      if (half_q == HalfW'(1)) begin
        tog_d  = tog_q - TogW'(1);
        half_d = HalfW'(FLASH_DIV);
      end else begin
        half_d = half_q - HalfW'(1);
      end
    end
  end

  // Scan prescaler and digit index; tick also marks the dead-time slot.
  assign tick = (presc_q == PrescW'(SCAN_DIV - 1));

  always_comb begin
    presc_d = tick ? '0 : presc_q + PrescW'(1);
    idx_d   = idx_q;
    if (tick) idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
  end

  // Output decode with blanking priority.
  always_comb begin
    cur       = 4'd0;
    cur_blank = 1'b1;
    case (idx_q)
      2'd0:    begin cur = digits_q[3:0];  cur_blank = blank_q[0]; end
      2'd1:    begin cur = digits_q[7:4];  cur_blank = blank_q[1]; end
      2'd2:    begin cur = digits_q[11:8]; cur_blank = blank_q[2]; end
      default: ;
    endcase
    seg_n_d = SEG_BLANK;
    dig_n_d = 3'b111;
    if (enable_i && !flash_dark && !tick && !cur_blank) begin
      seg_n_d = hex2seg(cur);
      dig_n_d = ~(3'b001 << idx_q);
    end
  end

  // Conversion and digit state.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      src_q        <= 8'd0;
      last_value_q <= 8'd0;
      last_mode_q  <= 1'b0;
      pending_q    <= 1'b0;
      digits_q     <= 12'd0;
      blank_q      <= 3'b110;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      last_value_q <= last_value_d;
      last_mode_q  <= last_mode_d;
      pending_q    <= pending_d;
      digits_q     <= digits_d;
      blank_q      <= blank_d;
    end
  end

  // Scan, flash and registered display outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      presc_q <= '0;
      idx_q   <= 2'd0;
      tog_q   <= '0;
      half_q  <= '0;
      seg_n_q <= SEG_BLANK;
      dig_n_q <= 3'b111;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      tog_q   <= tog_d;
      half_q  <= half_d;
      seg_n_q <= seg_n_d;
      dig_n_q <= dig_n_d;
    end
  end

  assign seg_n_o = seg_n_q;
  assign dig_n_o = dig_n_q;
  assign busy_o  = (state_q != StIdle);

endmodule

// File: tb/tb_sevseg_scan_driver.sv
// Self-checking bench for sevseg_scan_driver with a cycle-level display model.
module tb_sevseg_scan_driver;

  localparam int unsigned SCAN_DIV      = 4;
  localparam int unsigned FLASH_DIV     = 8;
  localparam int unsigned FLASH_TOGGLES = 2;
  localparam logic [9:0]  DARK          = {3'b111, 7'h7F};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] value = 8'd0;
  logic       hex_mode = 1'b0;
  logic       enable = 1'b1;
  logic [6:0] seg_n;
  logic [2:0] dig_n;
  logic       busy;

  int cyc;
  int n_checks = 0;
  int n_fail = 0;
  int disp_v = 0;
  bit disp_hex = 1'b0;

  logic [6:0] seg_tab [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  sevseg_scan_driver #(
    .SCAN_DIV      (SCAN_DIV),
    .FLASH_DIV     (FLASH_DIV),
    .FLASH_TOGGLES (FLASH_TOGGLES)
  ) dut (
    .clk_i      (clk),
    .reset_i    (rst),
    .value_i    (value),
    .hex_mode_i (hex_mode),
    .enable_i   (enable),
    .seg_n_o    (seg_n),
    .dig_n_o    (dig_n),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Expected {dig_n, seg_n} for one slot of a displayed value.
  function automatic logic [9:0] slot_out(int v, bit hx, int slot);
    int d;
    bit blank;
    logic [2:0] dg;
    if (hx) begin
      d     = (slot == 0) ? v % 16 : v / 16;
      blank = (slot == 2);
    end else begin
      case (slot)
        0:       begin d = v % 10;        blank = 1'b0;     end
        1:       begin d = (v / 10) % 10; blank = (v < 10);  end
        default: begin d = v / 100;       blank = (v < 100); end
      endcase
    end
    if (blank) return DARK;
    dg = 3'b111;
    dg[slot] = 1'b0;
    return {dg, seg_tab[d]};
  endfunction

  // Steady-state output after n edges: last cycle of each slot is dead time.
  function automatic logic [9:0] exp_scan(int n, int v, bit hx);
    int m;
    if (n == 0) return DARK;
    m = n - 1;
    if (m % int'(SCAN_DIV) == int'(SCAN_DIV) - 1) return DARK;
    return slot_out(v, hx, (m / int'(SCAN_DIV)) % 3);
  endfunction

  task automatic test_reset();
    logic [9:0] e;
    bit found;
    rst = 1'b1; value = 8'd0; hex_mode = 1'b0; enable = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, dig_n, seg_n} !== {1'b0, DARK}) begin
      n_fail++;
      $display("FAIL reset_values: observed %b expected %b", {busy, dig_n, seg_n}, {1'b0, DARK});
    end
    rst = 1'b0; disp_v = 0; disp_hex = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      e = exp_scan(cyc, disp_v, disp_hex);
      n_checks++;
      if ({dig_n, seg_n} !== e) begin
        n_fail++;
        $display("FAIL reset_scan: cyc %0d observed %h expected %h", cyc, {dig_n, seg_n}, e);
      end
    end
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (dig_n == 3'b110) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL reset_lit_wait: observed no lit units slot within 12 cycles, required one");
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, dig_n, seg_n} !== {1'b0, DARK}) begin
      n_fail++;
      $display("FAIL async_reset: observed %b expected %b", {busy, dig_n, seg_n}, {1'b0, DARK});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({dig_n, seg_n} !== {3'b110, 7'h40}) begin
      n_fail++;
      $display("FAIL reset_index0: observed %h expected %h", {dig_n, seg_n}, {3'b110, 7'h40});
    end
  endtask

  task automatic test_decimal(input int v);
    logic [9:0] e;
    value = v[7:0]; hex_mode = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== (i < 9)) begin
        n_fail++;
        $display("FAIL dec_busy: value %0d cycle %0d observed %b expected %b", v, i, busy, i < 9);
      end
    end
    disp_v = v; disp_hex = 1'b0;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      e = exp_scan(cyc, disp_v, disp_hex);
      n_checks++;
      if ({dig_n, seg_n} !== e) begin
        n_fail++;
        $display("FAIL dec_scan: value %0d observed %h expected %h", v, {dig_n, seg_n}, e);
      end
    end
  endtask

  task automatic test_hex(input int v);
    logic [9:0] e;
    value = v[7:0]; hex_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e = (i == 2) ? DARK : exp_scan(cyc, disp_v, disp_hex);
      n_checks++;
      if ({dig_n, seg_n} !== e || (i < 2 && busy !== (i == 0))) begin
        n_fail++;
        $display("FAIL hex_latency: cycle %0d observed %b/%h expected %b/%h",
                 i, busy, {dig_n, seg_n}, i == 0, e);
      end
    end
    disp_v = v; disp_hex = 1'b1;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      e = exp_scan(cyc, disp_v, disp_hex);
      n_checks++;
      if ({dig_n, seg_n} !== e) begin
        n_fail++;
        $display("FAIL hex_scan: value %h observed %h expected %h", v, {dig_n, seg_n}, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] e;
    value = 8'd12; hex_mode = 1'b0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== (i < 18)) begin
        n_fail++;
        $display("FAIL b2b_busy: cycle %0d observed %b expected %b", i, busy, i < 18);
      end
      if (i == 3) value = 8'd34;
    end
    disp_v = 34; disp_hex = 1'b0;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      e = exp_scan(cyc, disp_v, disp_hex);
      n_checks++;
      if ({dig_n, seg_n} !== e) begin
        n_fail++;
        $display("FAIL b2b_scan: observed %h expected %h", {dig_n, seg_n}, e);
      end
    end
  endtask

  task automatic test_flash();
    logic [9:0] e;
    value = 8'd10; hex_mode = 1'b0;
    repeat (30) @(negedge clk);
    value = 8'd11;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      e = (i >= 10 && i <= 17) ? DARK : exp_scan(cyc, (i <= 9) ? 10 : 11, 1'b0);
      n_checks++;
      if ({dig_n, seg_n} !== e) begin
        n_fail++;
        $display("FAIL flash: cycle %0d observed %h expected %h", i, {dig_n, seg_n}, e);
      end
    end
    disp_v = 11; disp_hex = 1'b0;
  endtask

  task automatic test_random();
    logic [9:0] e;
    int v;
    bit hx;
    for (int k = 0; k < 8; k++) begin
      v  = int'($urandom_range(0, 255));
      hx = 1'($urandom_range(0, 1));
      value = v[7:0]; hex_mode = hx;
      disp_v = v; disp_hex = hx;
      repeat (32) @(negedge clk);
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        e = exp_scan(cyc, disp_v, disp_hex);
        n_checks++;
        if ({dig_n, seg_n} !== e) begin
          n_fail++;
          $display("FAIL rand_scan: value %0d hex %b observed %h expected %h",
                   v, hx, {dig_n, seg_n}, e);
        end
      end
    end
  endtask

  task automatic test_enable();
    logic [9:0] e;
    logic [7:0] v;
    enable = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_checks++;
      if ({dig_n, seg_n} !== DARK) begin
        n_fail++;
        $display("FAIL enable_dark: observed %h expected %h", {dig_n, seg_n}, DARK);
      end
    end
    v = (value == 8'd99 && !hex_mode) ? 8'd98 : 8'd99;
    value = v; hex_mode = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== (i < 9) || {dig_n, seg_n} !== DARK) begin
        n_fail++;
        $display("FAIL enable_busy: cycle %0d observed %b/%h expected %b/%h",
                 i, busy, {dig_n, seg_n}, i < 9, DARK);
      end
    end
    disp_v = int'(v); disp_hex = 1'b0;
    repeat (20) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      e = exp_scan(cyc, disp_v, disp_hex);
      n_checks++;
      if ({dig_n, seg_n} !== e) begin
        n_fail++;
        $display("FAIL enable_restore: observed %h expected %h", {dig_n, seg_n}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_decimal(205);
    test_decimal(7);
    test_hex(8'hAF);
    test_back_to_back();
    test_flash();
    test_random();
    test_enable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sevseg_scan_driver.md
Name: sevseg_scan_driver

Overview:
Downstream consumer of the 8-bit seven-segment PIO output. It converts the byte to three decimal digits or two hex digits and time-multiplexes them onto a 3-digit common-anode display (active-low segments and digit enables). It briefly flashes the display whenever the shown value changes, which highlights score updates.

Parameters:
SCAN_DIV, 50000, clk cycles per digit slot (1 kHz per digit at 50 MHz)
FLASH_DIV, 12500000, clk cycles per flash half-period
FLASH_TOGGLES, 6, flash half-periods after each value change (even; starts with the dark phase)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
value  in  8  byte from the PIO out_port, synchronous to clk
hex_mode  in  1  1 = two hex digits; 0 = three decimal digits
enable  in  1  0 = display dark; scanning and conversion continue
seg_n  out  7  active-low segments, bit0=a … bit6=g, registered
dig_n  out  3  active-low digit enables, bit0=units, registered
busy  out  1  conversion in flight (state != IDLE)

Behaviour:
- Reset (async, active-high) forces these values immediately:
  - outputs: seg_n=7'h7F, dig_n=3'b111, busy=0
  - state: FSM=IDLE, digit regs=0, last_value=0, last_mode=0, scan index=0, prescaler=0, flash inactive
- FSM states are IDLE, CONVERT and COMMIT.
- IDLE:
  - At any edge where {value,hex_mode} != {last_value,last_mode}, latch src=value and last_*, then go to CONVERT (decimal) or COMMIT (hex).
  - busy rises at that edge.
- CONVERT:
  - Sequential double-dabble, one bit per cycle, exactly 8 cycles, then COMMIT.
- COMMIT:
  - Write the three digit regs and return to IDLE.
  - Hex mode writes digit1=src[7:4], digit0=src[3:0], digit2=blank.
- Latency, from the detecting edge k: decimal digits update at edge k+9; hex at edge k+1.
- Input changes while busy:
  - A change while not IDLE sets a pending flag.
  - After COMMIT the FSM re-compares and restarts immediately; busy stays high with no IDLE cycle.
  - The latest input always wins.
- Leading-zero blanking (decimal):
  - hundreds blank if 0
  - tens blank if hundreds=0 and tens=0
  - units always lit
- Scan:
  - The prescaler counts 0..SCAN_DIV-1.
  - At terminal count the index advances 0→1→2→0.
- Dead time: on the cycle after the index changes, dig_n=111 (anti-ghosting); then dig_n drives the one-hot-low enable for the index.
- Blanked digit slots hold dig_n=111, seg_n=7F.
- Flash:
  - Starts on each COMMIT whose digit set differs from the previous one.
  - Loads a toggle counter with FLASH_TOGGLES and a half-period counter with FLASH_DIV.
  - Dark during odd phases, beginning with dark.
  - A new differing COMMIT during a flash restarts it.
  - A COMMIT with identical digits does not start a flash (e.g. a mode toggle back and forth).
- Output priority: enable=0 or flash-dark or dead time → seg_n=7F, dig_n=111; otherwise the decoded digit.
- Segment map:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - blank=7F

Decomposition:
- Package sevseg_pkg holds the state enum, the hex-to-segment constant table/function, and SEG_BLANK=7'h7F.
- One sub-module, sevseg_bin2bcd: start/done handshake, 8-bit in, three 4-bit BCD out, 8-cycle sequential double-dabble.

Test Plan:
(Bench parameters: SCAN_DIV=4, FLASH_DIV=8, FLASH_TOGGLES=2.)
- Assert reset mid-scan with a digit lit → seg_n=7F, dig_n=111 and busy=0 in the same cycle without a clock edge; after release, index=0.
- value=205, hex_mode=0 →
  - busy high for exactly 9 cycles
  - after the flash ends, slots show units 5 (dig_n=110, seg 12), tens 0 (101, 40), hundreds 2 (011, 24)
  - each slot is preceded by one 111 cycle
- value=7, decimal →
  - units slot seg 78
  - tens and hundreds slots dig_n=111
- hex_mode=1, value=8'hAF →
  - digits committed 1 cycle after detection
  - units F (0E), slot1 A (08), slot2 dark
- value 12 then 34 written 3 cycles into conversion →
  - busy continuously high until 34 commits
  - final digits 3, 4; tens slot seg 30, units slot seg 19
- Change 10→11 with enable=1 → dark 8 cycles, lit 8, then steady. Then set enable=0 → dig_n=111 permanently while busy/scan still operate.
